bp_be_stride_prefetch_issuer: RTL and testbench

// - Consumes loop descriptors from the backend loop-inference unit:

---
 rtl/bp_be_stride_prefetch_issuer_pkg.sv | 29 ++
 rtl/bp_be_stride_prefetch_issuer_if.sv | 33 +++
 rtl/bp_be_stride_prefetch_issuer_credit.sv | 30 +++
 rtl/bp_be_stride_prefetch_issuer.sv | 122 ++++++++++++
 tb/tb_bp_be_stride_prefetch_issuer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/bp_be_stride_prefetch_issuer_pkg.sv
// Shared types for the backend stride prefetch issuer: config selector, FSM states, loop descriptor.
// The descriptor struct is declared through a macro so each user can size it from its own parameters.
`define BP_BE_DECLARE_LOOP_DESC_S(vaddr_width_mp, stride_width_mp, output_range_mp) \
    typedef struct packed { \
        logic [vaddr_width_mp-1:0]  pc; \
        logic [vaddr_width_mp-1:0]  eff_addr; \
        logic [stride_width_mp-1:0] stride; \
        logic [output_range_mp-1:0] iterations; \
    } bp_be_loop_desc_s

package bp_be_stride_prefetch_issuer_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg
    } bp_params_e;

    typedef enum logic [0:0] {
        e_pf_idle,
        e_pf_issue
    } bp_be_pf_state_e;

    function automatic int vaddr_width_of(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return 39;
            default:          return 39;
        endcase
    endfunction

endpackage

// File: rtl/bp_be_stride_prefetch_issuer_if.sv
// Loop-descriptor (v/yumi), D$ prefetch (ready/valid), cancel and credit-return signals.
// slave is the issuer's view; master is the environment's view.
interface bp_be_stride_prefetch_issuer_if #(
    parameter int vaddr_width_p  = 39,
    parameter int output_range_p = 8,
    parameter int stride_width_p = 8
);
    logic                      loop_v;
    logic                      loop_yumi;
    logic [output_range_p-1:0] loop_iterations;
    logic [vaddr_width_p-1:0]  loop_pc;
    logic [vaddr_width_p-1:0]  loop_eff_addr;
    logic [stride_width_p-1:0] loop_stride;
    logic                      cancel;
    logic                      pf_v;
    logic                      pf_ready_and;
    logic [vaddr_width_p-1:0]  pf_addr;
    logic [vaddr_width_p-1:0]  pf_pc;
    logic                      credit_return;
    logic                      busy;

    modport slave (
        input  loop_v, loop_iterations, loop_pc, loop_eff_addr, loop_stride,
        input  cancel, pf_ready_and, credit_return,
        output loop_yumi, pf_v, pf_addr, pf_pc, busy
    );

    modport master (
        output loop_v, loop_iterations, loop_pc, loop_eff_addr, loop_stride,
        output cancel, pf_ready_and, credit_return,
        input  loop_yumi, pf_v, pf_addr, pf_pc, busy
    );
endinterface

// File: rtl/bp_be_stride_prefetch_issuer_credit.sv
// Saturating up/down counter tracking free prefetch credits; reset loads init_val_p.
// Latency: count_o updates the cycle after up_i/down_i; simultaneous up and down cancel.
// Backpressure: none itself; the issuer gates requests on count_o != 0.
module bp_be_stride_prefetch_issuer_credit #(
    parameter int max_val_p  = 4,
    parameter int init_val_p = 4,
    parameter int width_p    = $clog2(max_val_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               up_i,
    input  logic               down_i,
    output logic [width_p-1:0] count_o
);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_o <= width_p'(init_val_p);
        end else if (up_i && !down_i && (count_o != width_p'(max_val_p))) begin
            count_o <= count_o + 1'b1;
        end else if (down_i && !up_i && (count_o != '0)) begin
            count_o <= count_o - 1'b1;
        end
    end

    // A return with every credit already free means the D$ retired more than was issued.
    assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(up_i && !down_i && (count_o == width_p'(max_val_p))));

endmodule

// File: rtl/bp_be_stride_prefetch_issuer.sv
// Turns loop descriptors into bounded, page-limited bursts of stride prefetches to the D$.
// Latency: first pf_v one cycle after descriptor accept; one request per cycle thereafter.
// Backpressure: holds pf_v/pf_addr until pf_ready_and; stalls with no free credits.
module bp_be_stride_prefetch_issuer
    import bp_be_stride_prefetch_issuer_pkg::*;
#(
    parameter bp_params_e bp_params_p         = e_bp_default_cfg,
    parameter int         output_range_p      = 8,
    parameter int         stride_width_p      = 8,
    parameter int         max_prefetch_p      = 16,
    parameter int         max_outstanding_p   = 4,
    parameter int         page_offset_width_p = 12
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    bp_be_stride_prefetch_issuer_if.slave io
);

    localparam int vaddr_width_p   = vaddr_width_of(bp_params_p);
    localparam int count_width_lp  = $clog2(max_prefetch_p + 1);
    localparam int credit_width_lp = $clog2(max_outstanding_p + 1);
    localparam int page_width_lp   = vaddr_width_p - page_offset_width_p;

    `BP_BE_DECLARE_LOOP_DESC_S(vaddr_width_p, stride_width_p, output_range_p);

    bp_be_loop_desc_s           desc;
    bp_be_pf_state_e            state_r, state_n;
    logic [vaddr_width_p-1:0]   pc_r, addr_r, stride_r, stride_sext;
    logic [page_width_lp-1:0]   page_r;
    logic [count_width_lp-1:0]  count_r, count_clamped;
    logic [credit_width_lp-1:0] credits;
    logic                       accept, start, same_page, pf_v, handshake;

    assign desc = '{pc:         io.loop_pc,
                    eff_addr:   io.loop_eff_addr,
                    stride:     io.loop_stride,
                    iterations: io.loop_iterations};

    assign stride_sext   = {{(vaddr_width_p-stride_width_p){desc.stride[stride_width_p-1]}}, desc.stride};
    assign count_clamped = (32'(desc.iterations) > max_prefetch_p) ? count_width_lp'(max_prefetch_p)
                                                                   : count_width_lp'(desc.iterations);

    // A cancelled descriptor is still consumed but never starts a burst.
    assign accept    = io.loop_yumi;
    assign start     = accept & ~io.cancel & (count_clamped != '0) & (stride_sext != '0);
    assign same_page = (addr_r[vaddr_width_p-1:page_offset_width_p] == page_r);
    assign handshake = pf_v & io.pf_ready_and;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_pf_idle;
        end else begin
            state_r <= state_n;
        end
    end

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            e_pf_idle: begin
                if (start) state_n = e_pf_issue;
            end
            e_pf_issue: begin
                if (io.cancel || !same_page || (handshake && (count_r == count_width_lp'(1))))
                    state_n = e_pf_idle;
            end
            default: state_n = e_pf_idle;
        endcase
    end

    always_comb begin
        io.loop_yumi = 1'b0;
        io.busy      = 1'b0;
        pf_v         = 1'b0;
        unique case (state_r)
            e_pf_idle: begin
                io.loop_yumi = io.loop_v;
            end
            e_pf_issue: begin
                io.busy = 1'b1;
                pf_v    = (credits != '0) & same_page & ~io.cancel;
            end
            default: ;
        endcase
    end

    assign io.pf_v    = pf_v;
    assign io.pf_addr = addr_r;
    assign io.pf_pc   = pc_r;

    // Accept only happens in IDLE and handshakes only in ISSUE, so the two never collide.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pc_r     <= '0;
            addr_r   <= '0;
            stride_r <= '0;
            page_r   <= '0;
            count_r  <= '0;
        end else if (accept) begin
            pc_r     <= desc.pc;
            addr_r   <= desc.eff_addr + stride_sext;
            stride_r <= stride_sext;
            page_r   <= desc.eff_addr[vaddr_width_p-1:page_offset_width_p];
            count_r  <= count_clamped;
        end else if (handshake) begin
            addr_r   <= addr_r + stride_r;
            count_r  <= count_r - 1'b1;
        end
    end

    bp_be_stride_prefetch_issuer_credit #(
        .max_val_p  (max_outstanding_p),
        .init_val_p (max_outstanding_p)
    ) credit_counter (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .up_i      (io.credit_return),
        .down_i    (handshake),
        .count_o   (credits)
    );

endmodule

// File: tb/tb_bp_be_stride_prefetch_issuer.sv
// Directed and random stimulus for the stride prefetch issuer against a burst-list reference model.
module tb_bp_be_stride_prefetch_issuer;
    import bp_be_stride_prefetch_issuer_pkg::*;

    localparam int VA       = vaddr_width_of(e_bp_default_cfg);
    localparam int PAGE_OFF = 12;
    localparam int MAX_PF   = 16;
    localparam int MAX_OUT  = 4;

    logic clk_i = 1'b0;
    logic reset_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    bp_be_stride_prefetch_issuer_if #(.vaddr_width_p(VA), .output_range_p(8), .stride_width_p(8)) bus ();

    bp_be_stride_prefetch_issuer #(
        .bp_params_p         (e_bp_default_cfg),
        .output_range_p      (8),
        .stride_width_p      (8),
        .max_prefetch_p      (MAX_PF),
        .max_outstanding_p   (MAX_OUT),
        .page_offset_width_p (PAGE_OFF)
    ) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .io        (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: list of in-page addresses still to issue, plus remaining burst length.
    bit              m_busy    = 1'b0;
    int              m_credits = MAX_OUT;
    int              m_left    = 0;
    logic [VA-1:0]   m_pc      = '0;
    logic [VA-1:0]   m_q[$];
    logic [VA-1:0]   seen[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] seen_at(int i);
        return (i < seen.size()) ? 64'(seen[i]) : '1;
    endfunction

    task automatic model_start(input logic [VA-1:0] pc, input logic [VA-1:0] eff,
                               input logic [7:0] stride, input logic [7:0] iter);
        logic [VA-1:0] step_v, a;
        int n;
        step_v = {{(VA-8){stride[7]}}, stride};
        n = (int'(iter) > MAX_PF) ? MAX_PF : int'(iter);
        if (n == 0 || stride == 8'd0) return;
        m_busy = 1'b1;
        m_left = n;
        m_pc   = pc;
        m_q.delete();
        a = eff;
        for (int k = 0; k < n; k++) begin
            a = a + step_v;
            if (a[VA-1:PAGE_OFF] != eff[VA-1:PAGE_OFF]) break;
            m_q.push_back(a);
        end
    endtask

    task automatic step(input bit v, input logic [VA-1:0] pc, input logic [VA-1:0] eff,
                        input logic [7:0] stride, input logic [7:0] iter,
                        input bit rdy, input bit ret, input bit cxl);
        bit exp_pfv, ret_eff, hs;
        @(negedge clk_i);
        ret_eff              = ret && (m_credits < MAX_OUT);
        bus.loop_v           = v;
        bus.loop_pc          = pc;
        bus.loop_eff_addr    = eff;
        bus.loop_stride      = stride;
        bus.loop_iterations  = iter;
        bus.pf_ready_and     = rdy;
        bus.credit_return    = ret_eff;
        bus.cancel           = cxl;
        #1;
        exp_pfv = m_busy && (m_q.size() > 0) && (m_credits > 0) && !cxl;
        chk("yumi", 64'(bus.loop_yumi), 64'(v && !m_busy));
        chk("busy", 64'(bus.busy), 64'(m_busy));
        chk("pf_v", 64'(bus.pf_v), 64'(exp_pfv));
        if (exp_pfv && bus.pf_v) begin
            chk("pf_addr", 64'(bus.pf_addr), 64'(m_q[0]));
            chk("pf_pc", 64'(bus.pf_pc), 64'(m_pc));
        end
        if (bus.pf_v && rdy) seen.push_back(bus.pf_addr);
        hs = exp_pfv && rdy;
        m_credits = m_credits + int'(ret_eff) - int'(hs);
        if (m_busy) begin
            if (cxl || m_q.size() == 0) begin
                m_busy = 1'b0;
            end else if (hs) begin
                void'(m_q.pop_front());
                m_left--;
                if (m_left == 0) m_busy = 1'b0;
            end
        end else if (v && !cxl) begin
            model_start(pc, eff, stride, iter);
        end
    endtask

    task automatic idle(input int n, input bit rdy, input bit ret);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 8'd0, 8'd0, rdy, ret, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_n_i         = 1'b0;
        bus.loop_v        = 1'b0;
        bus.cancel        = 1'b0;
        bus.pf_ready_and  = 1'b0;
        bus.credit_return = 1'b0;
        #1;
        chk("rst_pf_v", 64'(bus.pf_v), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_yumi", 64'(bus.loop_yumi), 64'd0);
        m_busy    = 1'b0;
        m_credits = MAX_OUT;
        m_left    = 0;
        m_q.delete();
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
    endtask

    initial begin
        bus.loop_v = 1'b0; bus.loop_pc = '0; bus.loop_eff_addr = '0; bus.loop_stride = '0;
        bus.loop_iterations = '0; bus.cancel = 1'b0; bus.pf_ready_and = 1'b0; bus.credit_return = 1'b0;
        do_reset();

        // Basic burst
        seen.delete();
        step(1'b1, 39'h400, 39'h1000, 8'h08, 8'd3, 1'b1, 1'b0, 1'b0);
        idle(4, 1'b1, 1'b0);
        chk("basic_cnt", 64'(seen.size()), 64'd3);
        chk("basic_a0", seen_at(0), 64'h1008);
        chk("basic_a2", seen_at(2), 64'h1018);
        idle(5, 1'b0, 1'b1);

        // Negative stride
        seen.delete();
        step(1'b1, 39'h480, 39'h2040, 8'hF0, 8'd2, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1, 1'b0);
        chk("neg_cnt", 64'(seen.size()), 64'd2);
        chk("neg_a0", seen_at(0), 64'h2030);
        chk("neg_a1", seen_at(1), 64'h2020);
        idle(5, 1'b0, 1'b1);

        // Page cross
        seen.delete();
        step(1'b1, 39'h500, 39'h1FF0, 8'h08, 8'd5, 1'b1, 1'b0, 1'b0);
        idle(4, 1'b1, 1'b0);
        chk("page_cnt", 64'(seen.size()), 64'd1);
        chk("page_a0", seen_at(0), 64'h1FF8);
        idle(5, 1'b0, 1'b1);

        // Credit throttle
        seen.delete();
        step(1'b1, 39'h600, 39'h3000, 8'h04, 8'd10, 1'b1, 1'b0, 1'b0);
        idle(8, 1'b1, 1'b0);
        chk("cred_stall", 64'(seen.size()), 64'd4);
        idle(1, 1'b1, 1'b1);
        idle(3, 1'b1, 1'b0);
        chk("cred_one", 64'(seen.size()), 64'd5);
        idle(1, 1'b1, 1'b1);
        idle(1, 1'b1, 1'b1);
        idle(1, 1'b1, 1'b0);
        idle(2, 1'b1, 1'b0);
        chk("cred_net0", 64'(seen.size()), 64'd7);
        step(1'b0, '0, '0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1);
        idle(6, 1'b0, 1'b1);

        // Backpressure then cancel
        seen.delete();
        step(1'b1, 39'h700, 39'h4000, 8'h10, 8'd6, 1'b0, 1'b0, 1'b0);
        idle(5, 1'b0, 1'b0);
        step(1'b0, '0, '0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b1, 1'b0);
        chk("cancel_nohs", 64'(seen.size()), 64'd0);

        // Degenerate descriptors and cancel while idle
        step(1'b1, 39'h800, 39'h1000, 8'h08, 8'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 39'h800, 39'h1000, 8'h00, 8'd5, 1'b1, 1'b0, 1'b0);
        step(1'b1, 39'h800, 39'h1000, 8'h08, 8'd5, 1'b1, 1'b0, 1'b1);
        idle(3, 1'b1, 1'b0);
        chk("degen_nohs", 64'(seen.size()), 64'd0);

        // Clamp to max_prefetch_p
        step(1'b1, 39'h900, 39'h5000, 8'h01, 8'd200, 1'b1, 1'b0, 1'b0);
        idle(25, 1'b1, 1'b1);
        chk("clamp_cnt", 64'(seen.size()), 64'd16);
        chk("clamp_last", seen_at(15), 64'h5010);

        // Reset mid-burst restores full credits
        step(1'b1, 39'hA00, 39'h6000, 8'h20, 8'd12, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1, 1'b0);
        do_reset();
        seen.delete();
        step(1'b1, 39'hB00, 39'h7000, 8'h08, 8'd8, 1'b1, 1'b0, 1'b0);
        idle(8, 1'b1, 1'b0);
        chk("rst_credits", 64'(seen.size()), 64'd4);
        idle(6, 1'b0, 1'b1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] it;
            it = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 20));
            step(($urandom_range(0, 3) == 0), VA'($urandom), VA'($urandom), 8'($urandom), it,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 39) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
